// File: rtl/key_debounce.sv
// Per-key 2-flop synchronizer and debounce FSM for active-low pushbuttons.
// Optional auto-repeat on held keys: define KEY_REPEAT_EN.
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                Resetn,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] KEY_STATE,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE
);

  localparam int CW =
    (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef KEY_REPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX < 1) ? 1 : $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_ONE   = RW'(1);
`else
  // Repeat timing is meaningless without auto-repeat.
  if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_rpt_unused
  end
`endif

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } state_e;

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] s;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    state_e        st_q;
    logic [CW-1:0] cnt_q;
    logic          lvl_q;
    logic          press_q;
    logic          rel_q;

`ifdef KEY_REPEAT_EN
    logic [RW-1:0] rpt_q;
    logic [RW-1:0] rpt_inc;
    logic          first_q;
    logic          rpt_hit;
    logic          rpt_tick;

    assign rpt_inc  = rpt_q + R_ONE;
    assign rpt_hit  = rpt_inc == (first_q ? R_FIRST : R_NEXT);
    // Hold time accrues whenever the accepted level and input agree.
    assign rpt_tick = s[g] &&
                      (st_q == PRESSED || st_q == RELEASE_CHK);
`endif

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
        st_q    <= RELEASED;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_q   <= '0;
        first_q <= 1'b1;
`endif
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        unique case (st_q)
          RELEASED: begin
            if (s[g]) begin
              st_q  <= PRESS_CHK;
              cnt_q <= CNT_ONE;
            end else begin
              cnt_q <= '0;
            end
          end
          PRESS_CHK: begin
            if (!s[g]) begin
              st_q  <= RELEASED;
              cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
              st_q    <= PRESSED;
              cnt_q   <= '0;
              lvl_q   <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!s[g]) begin
              st_q  <= RELEASE_CHK;
              cnt_q <= CNT_ONE;
            end else begin
              cnt_q <= '0;
            end
          end
          RELEASE_CHK: begin
            if (s[g]) begin
              st_q  <= PRESSED;
              cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
              st_q  <= RELEASED;
              cnt_q <= '0;
              lvl_q <= 1'b0;
              rel_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            st_q  <= RELEASED;
            cnt_q <= '0;
          end
        endcase
`ifdef KEY_REPEAT_EN
        if (st_q == PRESS_CHK) begin
          rpt_q   <= '0;
          first_q <= 1'b1;
        end else if (rpt_tick) begin
          if (rpt_hit) begin
            rpt_q   <= '0;
            first_q <= 1'b0;
            press_q <= 1'b1;
          end else begin
            rpt_q <= rpt_inc;
          end
        end
`endif
      end
    end

    assign KEY_STATE[g]   = lvl_q;
    assign KEY_PRESS[g]   = press_q;
    assign KEY_RELEASE[g] = rel_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios then random bouncing keys,
// all cycles compared against a run-length reference model.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int total = 0;
  int bad   = 0;

  bit [NK-1:0] k1, k2, lvl;
  bit [NK-1:0] m_state, m_press, m_rel;
  int          run  [NK];
  int          hold [NK];
  int          pcnt [NK];
  int          rcnt [NK];

  key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLOCK_50   (clk),
    .Resetn     (rst_n),
    .KEY        (key),
    .KEY_STATE  (key_state),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic void model_reset();
    k1 = '1;
    k2 = '1;
    lvl = '0;
    m_state = '0;
    m_press = '0;
    m_rel = '0;
    for (int i = 0; i < NK; i++) begin
      run[i]  = 0;
      hold[i] = 0;
    end
  endfunction

  // A change is accepted once the synchronized input has differed
  // from the accepted level on DB+1 consecutive edges.
  function automatic void model_step(input logic [NK-1:0] kin);
    bit s;
    for (int i = 0; i < NK; i++) begin
      s = ~k2[i];
      k2[i] = k1[i];
      k1[i] = kin[i];
      m_press[i] = 1'b0;
      m_rel[i] = 1'b0;
      if (s != lvl[i]) begin
        run[i]++;
        if (run[i] == DB + 1) begin
          lvl[i] = s;
          run[i] = 0;
          hold[i] = 0;
          if (s) m_press[i] = 1'b1;
          else m_rel[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
`ifdef KEY_REPEAT_EN
        if (lvl[i] && s) begin
          hold[i]++;
          if (hold[i] == RD ||
              (hold[i] > RD && (hold[i] - RD) % RP == 0))
            m_press[i] = 1'b1;
        end
`endif
      end
    end
    m_state = lvl;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(key);
    else model_reset();
    #1;
    chk("state", key_state, m_state);
    chk("press", key_press, m_press);
    chk("release", key_release, m_rel);
    chk("excl", key_press & key_release, 0);
    for (int i = 0; i < NK; i++) begin
      pcnt[i] += int'(key_press[i]);
      rcnt[i] += int'(key_release[i]);
    end
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  int lat;
  int p0;
  int offs[$];
  int exp_off[$];
  int seg[NK];

  initial begin
    model_reset();
    for (int i = 0; i < NK; i++) begin
      pcnt[i] = 0;
      rcnt[i] = 0;
      seg[i]  = 0;
    end

    // reset asserted with all keys held: outputs clear with no clock
    key = 4'b0000;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_state", key_state, 0);
    chk("rst_press", key_press, 0);
    chk("rst_rel", key_release, 0);
    ticks(3);
    rst_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick();
      chk("t1_press", key_press, (j == 7) ? 4'hF : 4'h0);
    end
    tick();
    chk("t1_state", key_state, 4'hF);
    chk("t1_press_end", key_press, 0);
    key = 4'hF;
    ticks(12);
    chk("t1_released", key_state, 0);

    // clean press / release on key 0
    key[0] = 1'b0;
    p0 = pcnt[0];
    lat = 0;
    while (!key_state[0] && lat < 20) begin
      tick();
      lat++;
    end
    chk("t2_press_lat", lat, 7);
    ticks(5);
    chk("t2_npress", pcnt[0] - p0, 1);
    key[0] = 1'b1;
    p0 = rcnt[0];
    lat = 0;
    while (!key_release[0] && lat < 20) begin
      tick();
      lat++;
    end
    chk("t2_rel_lat", lat, 7);
    ticks(5);
    chk("t2_nrel", rcnt[0] - p0, 1);

    // bounce on key 1 before settling low
    p0 = pcnt[1];
    key[1] = 1'b0;
    ticks(3);
    key[1] = 1'b1;
    ticks(1);
    key[1] = 1'b0;
    lat = 0;
    while (!key_press[1] && lat < 20) begin
      tick();
      lat++;
    end
    chk("t3_lat", lat, 7);
    ticks(5);
    chk("t3_npress", pcnt[1] - p0, 1);
    key[1] = 1'b1;
    ticks(12);

    // keys 2 and 3 together, then 3 released alone
    key = 4'b0011;
    lat = 0;
    while (key_press == 0 && lat < 20) begin
      tick();
      lat++;
    end
    chk("t4_lat", lat, 7);
    chk("t4_press", key_press, 4'b1100);
    ticks(3);
    key[3] = 1'b1;
    lat = 0;
    while (key_release == 0 && lat < 20) begin
      tick();
      lat++;
    end
    chk("t4_rel", key_release, 4'b1000);
    chk("t4_state", key_state, 4'b0100);
    key = 4'hF;
    ticks(12);

    // reset in the middle of a press debounce
    key[0] = 1'b0;
    p0 = pcnt[0];
    ticks(5);
    rst_n = 1'b0;
    key[0] = 1'b1;
    #1;
    chk("t5_async", key_state | key_press, 0);
    ticks(3);
    rst_n = 1'b1;
    ticks(12);
    chk("t5_npress", pcnt[0] - p0, 0);
    chk("t5_state", key_state, 0);

    // long hold on key 0: auto-repeat when enabled
`ifdef KEY_REPEAT_EN
    exp_off.push_back(20);
    exp_off.push_back(28);
    exp_off.push_back(36);
    exp_off.push_back(44);
    exp_off.push_back(52);
`endif
    key[0] = 1'b0;
    lat = 0;
    while (!key_press[0] && lat < 20) begin
      tick();
      lat++;
    end
    chk("t6_lat", lat, 7);
    p0 = rcnt[0];
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (key_press[0]) offs.push_back(k);
      if (k == 57) key[0] = 1'b1;
    end
    chk("t6_nrep", offs.size(), exp_off.size());
    for (int i = 0; i < offs.size() && i < exp_off.size(); i++)
      chk("t6_off", offs[i], exp_off[i]);
    chk("t6_rel", rcnt[0] - p0, 1);

    // random bouncing keys with occasional reset
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (seg[i] == 0) begin
          key[i] = 1'($urandom_range(0, 1));
          seg[i] = ($urandom_range(0, 9) < 6)
                   ? int'($urandom_range(1, 4))
                   : int'($urandom_range(5, 40));
        end else begin
          seg[i]--;
        end
      end
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 1499) == 0) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    key = 4'hF;
    ticks(15);
    chk("end_state", key_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
